// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory responder.
// No logic; no latency or backpressure of its own.
package imem_pkg;

  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0013;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian bytes into words and owns the LOAD/RUN FSM.
// Latency: one word write in the cycle the 4th byte or load_done is accepted; backpressure: load_ready drops once in RUN or during reset.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [7:0]    load_byte,
  input  logic          load_done,
  output logic          load_ready,
  output logic          run,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic [AW:0]   loaded_words
);

  imem_state_t state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [AW:0] wptr_q, wptr_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] word_d;
  logic        accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      bcnt_q  <= '0;
      wptr_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      wptr_q  <= wptr_d;
      asm_q   <= asm_d;
    end
  end

  // Lanes at or above bcnt are always zero in asm_q, so a partial word needs no masking.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    wptr_d     = wptr_q;
    asm_d      = asm_q;
    word_d     = asm_q;
    load_ready = 1'b0;
    accept     = 1'b0;
    wr_en      = 1'b0;
    if (state_q == LOAD && !reset) begin
      load_ready = 1'b1;
      accept     = load_valid;
      if (accept) begin
        for (int i = 0; i < 4; i++) begin
          if (bcnt_q == 2'(i)) word_d[8*i +: 8] = load_byte;
        end
        bcnt_d = bcnt_q + 2'd1;
        asm_d  = word_d;
      end
      if ((accept && bcnt_q == 2'd3) || (load_done && (accept || bcnt_q != 2'd0))) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + 1'b1;
        bcnt_d = '0;
        asm_d  = '0;
      end
      if (load_done || (wr_en && wptr_q == (AW+1)'(DEPTH - 1))) state_d = RUN;
    end
  end

  assign run          = (state_q == RUN);
  assign wr_addr      = wptr_q[AW-1:0];
  assign wr_data      = word_d;
  assign loaded_words = wptr_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction memory: streamed-in program, then word fetches with NOP+fault on bad addresses.
// Latency: fetch response registered one cycle after ireq; backpressure: none, one response per cycle.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_done,
  output logic        load_ready,
  input  logic        ireq,
  input  logic [31:0] iaddr,
  output logic [31:0] idata,
  output logic        ivalid,
  output logic        ifault,
  output logic        boot_done,
  output logic [AW:0] loaded_words
);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          run;
  logic [31:0]   mem [DEPTH];
  logic [29:0]   idx;
  logic          fault;

  imem_loader #(.DEPTH(DEPTH)) u_loader (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_byte    (load_byte),
    .load_done    (load_done),
    .load_ready   (load_ready),
    .run          (run),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .loaded_words (loaded_words)
  );

  // Program storage deliberately survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign idx   = iaddr[31:2];
  assign fault = (iaddr[1:0] != 2'b00) || (idx >= 30'(loaded_words));
  assign boot_done = run;

  always_ff @(posedge clk) begin
    if (reset) begin
      idata  <= '0;
      ivalid <= 1'b0;
      ifault <= 1'b0;
    end else begin
      ivalid <= ireq && run;
      if (ireq && run) begin
        idata  <= fault ? NOP_INSN : mem[idx[AW-1:0]];
        ifault <= fault;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboarded bench for imem_responder (DEPTH=4): loader, fetch, faults, fill and reset cases.
module tb_imem_responder;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_done;
  logic        load_ready;
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        ivalid;
  logic        ifault;
  logic        boot_done;
  logic [2:0]  loaded_words;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  imem_responder #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_byte    (load_byte),
    .load_done    (load_done),
    .load_ready   (load_ready),
    .ireq         (ireq),
    .iaddr        (iaddr),
    .idata        (idata),
    .ivalid       (ivalid),
    .ifault       (ifault),
    .boot_done    (boot_done),
    .loaded_words (loaded_words)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; load_valid = 1'b0; load_done = 1'b0; ireq = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic done);
    load_valid = 1'b1; load_byte = b; load_done = done;
    tick();
    load_valid = 1'b0; load_done = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic f);
    ireq = 1'b1; iaddr = a;
    exp_q.push_back('{data: d, fault: f});
    tick();
    ireq = 1'b0;
  endtask

  task automatic drain(input string name);
    ireq = 1'b0;
    tick(); tick();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ivalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ivalid: got ivalid=1 idata=%h expected no response", idata);
        end else begin
          e = exp_q.pop_front();
          chk("sb_idata", idata, e.data);
          chk("sb_ifault", 32'(ifault), 32'(e.fault));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_byte = 8'h00; load_done = 1'b0;
    ireq = 1'b0; iaddr = 32'h0;
    fork
      monitor();
    join_none

    // Reset values
    tick(); tick();
    @(negedge clk);
    chk("rst_idata", idata, 32'h0);
    chk("rst_ivalid", 32'(ivalid), 32'd0);
    chk("rst_ifault", 32'(ifault), 32'd0);
    chk("rst_boot_done", 32'(boot_done), 32'd0);
    chk("rst_loaded_words", 32'(loaded_words), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("load_ready_after_rst", 32'(load_ready), 32'd1);

    // Load two words with fetch requests active during LOAD (must be ignored)
    begin
      logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h11, 8'h00};
      ireq = 1'b1; iaddr = 32'h0;
      for (int i = 0; i < 8; i++) begin
        load_valid = 1'b1; load_byte = prog[i];
        tick();
        chk("load_ivalid", 32'(ivalid), 32'd0);
      end
      load_valid = 1'b0; load_done = 1'b1;
      tick();
      load_done = 1'b0; ireq = 1'b0;
      @(negedge clk);
      chk("load_done_ivalid", 32'(ivalid), 32'd0);
      chk("boot_done_2w", 32'(boot_done), 32'd1);
      chk("loaded_words_2w", 32'(loaded_words), 32'd2);
      chk("load_ready_run", 32'(load_ready), 32'd0);
      @(posedge clk); #1;
    end

    // Fetches: good, faults, back-to-back
    fetch(32'h0, 32'h0000_0013, 1'b0);
    fetch(32'h4, 32'h0011_00B3, 1'b0);
    fetch(32'h2, 32'h0000_0013, 1'b1);
    fetch(32'h8, 32'h0000_0013, 1'b1);
    fetch(32'hC, 32'h0000_0013, 1'b1);
    fetch(32'h0, 32'h0000_0013, 1'b0);
    fetch(32'h4, 32'h0011_00B3, 1'b0);
    fetch(32'h0, 32'h0000_0013, 1'b0);
    drain("drain_fetch1");
    chk("idata_hold", idata, 32'h0000_0013);
    // Loader inputs ignored in RUN
    send(8'hFF, 1'b1);
    chk("run_ignores_load", 32'(loaded_words), 32'd2);

    // Reset while a response is in flight
    ireq = 1'b1; iaddr = 32'h4;
    exp_q.push_back('{data: 32'h0011_00B3, fault: 1'b0});
    tick();
    reset = 1'b1;
    tick();
    ireq = 1'b0;
    @(negedge clk);
    chk("midrst_ivalid", 32'(ivalid), 32'd0);
    chk("midrst_boot_done", 32'(boot_done), 32'd0);
    chk("midrst_loaded_words", 32'(loaded_words), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_load_ready", 32'(load_ready), 32'd1);
    chk("midrst_queue", 32'(exp_q.size()), 32'd0);

    // Partial word: load_done together with the second byte
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    chk("partial_loaded_words", 32'(loaded_words), 32'd1);
    chk("partial_boot_done", 32'(boot_done), 32'd1);
    fetch(32'h0, 32'h0000_BBAA, 1'b0);
    fetch(32'h4, 32'h0000_0013, 1'b1);
    drain("drain_partial");

    // load_done on the 4th byte of a word: single write
    do_reset();
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b1);
    chk("done4_loaded_words", 32'(loaded_words), 32'd2);
    fetch(32'h4, 32'h8877_6655, 1'b0);
    fetch(32'h0, 32'h4433_2211, 1'b0);
    fetch(32'h8, 32'h0000_0013, 1'b1);
    drain("drain_done4");

    // Fill to DEPTH with 20 bytes; the last 4 are refused
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      send(8'(i), 1'b0);
      if (i == 15) chk("fill_boot_b15", 32'(boot_done), 32'd0);
      if (i == 16) chk("fill_boot_b16", 32'(boot_done), 32'd1);
      if (i >= 16) chk("fill_load_ready", 32'(load_ready), 32'd0);
    end
    chk("fill_loaded_words", 32'(loaded_words), 32'd4);
    fetch(32'h0, 32'h0403_0201, 1'b0);
    fetch(32'hC, 32'h100F_0E0D, 1'b0);
    fetch(32'h10, 32'h0000_0013, 1'b1);
    fetch(32'h7, 32'h0000_0013, 1'b1);
    drain("drain_fill");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the single-cycle RISC-V `CPU`: the memory side of the CPU's `iaddr`→`idata` fetch interface. After reset it accepts a program as a little-endian byte stream, then serves word fetches with one-cycle latency. Out-of-range and misaligned fetches return a NOP and raise a fault flag. It replaces the bench-local instruction array so programs can be streamed in at run time.

## Interface
Parameters:
- `DEPTH`, 256: memory size in 32-bit words; power of two, ≥ 4.
- `NOP_INSN`, 32'h0000_0013: word returned on fault (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `load_valid` in 1: program byte offered.
- `load_byte` in 8: program byte, little-endian order within each word.
- `load_done` in 1: end of program (single-cycle pulse).
- `load_ready` out 1: loader accepts bytes.
- `ireq` in 1: fetch request.
- `iaddr` in 32: byte address from the CPU.
- `idata` out 32: fetched instruction.
- `ivalid` out 1: `idata` valid this cycle.
- `ifault` out 1: the fetch was misaligned or beyond the loaded words.
- `boot_done` out 1: program loaded, fetch port live.
- `loaded_words` out $clog2(DEPTH)+1: number of words written.

## Operation
- States: `LOAD` (reset state) and `RUN`. There is no path from `RUN` back to `LOAD` except `reset`.
- **LOAD**
  - `load_ready = (state==LOAD) && !reset`.
  - A byte is accepted when `load_valid && load_ready`. It goes into byte lane `bcnt` (0..3) of the assembly register, then `bcnt++`.
  - On the 4th byte the word is written to `mem[wptr]`, then `wptr++`, `bcnt` clears, and `loaded_words` is incremented.
  - The write that makes `wptr==DEPTH` forces a transition to `RUN`. Further bytes are ignored.
  - `load_done` with `bcnt!=0`: the partial word is written with zero upper lanes, counted, and the block moves to `RUN`.
  - `load_done` with `bcnt==0`: go to `RUN` with no write.
  - `load_valid` and `load_done` in the same cycle: the byte is accepted first and included in the final word.
  - `ireq` is ignored in LOAD; `ivalid` stays 0.
- **RUN**
  - `boot_done = 1` and `load_ready = 0`. `load_valid` and `load_done` are ignored.
  - Each cycle with `ireq=1`, the request is decoded with `idx = iaddr[31:2]`.
  - Fault condition: `iaddr[1:0]!=0` or `idx >= loaded_words`. On fault the response is `idata = NOP_INSN`, `ifault = 1`.
  - Otherwise the response is `idata = mem[idx]`, `ifault = 0`.
- Memory contents are not cleared by `reset`. Words at or above `loaded_words` are never returned.

## Timing
- Reset values (register outputs after a reset edge): `idata = 0`, `ivalid = 0`, `ifault = 0`, `boot_done = 0`, `loaded_words = 0`. Internally `bcnt = 0`, `wptr = 0`, state = `LOAD`.
- `load_ready` is combinational; it is 0 while `reset` is high.
- Fetch latency is exactly 1 cycle. A request sampled at edge N has `ivalid`, `idata` and `ifault` valid after edge N. They hold until edge N+1.
- With no request, `ivalid = 0` and `idata` holds its last value.
- Back-to-back requests run at full throughput: one response per cycle, no backpressure.
- Loader throughput is 1 byte/cycle, so a word takes 4 accepted bytes.
- `boot_done` rises on the edge after the final write or `load_done`. The first fetch is accepted on that same cycle.
- Reset mid-load or mid-fetch: the next edge returns the block to `LOAD` with all counters at 0. An in-flight response is dropped (`ivalid = 0`).

## Structure
- Package `imem_pkg` holds `NOP_INSN_DEFAULT` and the state enum `imem_state_t {LOAD, RUN}`.
- Sub-module `imem_loader` contains the byte-lane assembler, `bcnt`, `wptr`, and the done/full logic. It outputs a write-enable, address and data.
- The top level holds the memory array, the fetch pipeline register, and fault decode.

## Test plan
- **Load and fetch:** reset, stream bytes 13 00 00 00 B3 00 11 00, pulse `load_done`.
  - Expect `loaded_words = 2` and `boot_done = 1`.
  - Fetch 0x0 gives `idata = 0x00000013`, `ifault = 0`.
  - Fetch 0x4 gives `0x001100B3` one cycle later.
- **Partial word:** stream AA BB, with `load_done` in the same cycle as BB.
  - Expect `loaded_words = 1`.
  - Fetch 0x0 gives `0x0000BBAA`.
- **Faults:** with 2 words loaded, fetch 0x2 and then 0x8.
  - Both give `idata = 0x00000013` and `ifault = 1`.
- **Fill to DEPTH:** with `DEPTH = 4`, stream 20 bytes.
  - `boot_done` rises after byte 16 and `loaded_words = 4`.
  - Bytes 17–20 are ignored and `load_ready` stays 0.
- **Back-to-back and LOAD-state fetches:** issue `ireq` with addresses 0, 4, 0 on consecutive cycles.
  - Expect three consecutive `ivalid` pulses carrying the correct words.
  - `ireq` issued during LOAD gives `ivalid = 0`.
- **Reset mid-operation:** assert `reset` in RUN mid-fetch.
  - Next cycle: `ivalid = 0`, `boot_done = 0`, `loaded_words = 0`, `load_ready = 1` after `reset` deasserts.
